// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and width defaults for the program loader.
package loader_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam int CSUM_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_HOLD,
        ST_DONE,
        ST_ERR
    } state_t;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: host stream, instruction-memory write port and CPU control of the loader.
interface program_loader_if
    import loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              start;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, error
    );
    modport slave (
        input  start, in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, error
    );
endinterface

// File: rtl/loader_csum_acc.sv
// loader_csum_acc: running modulo-2^W sum of payload words with synchronous clear.
module loader_csum_acc
    import loader_pkg::*;
#(
    parameter int W = CSUM_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_sum
);
    logic [W-1:0] r_sum;

    always_ff @(posedge clock) begin
        if (reset || i_clr) r_sum <= '0;
        else if (i_en) r_sum <= r_sum + i_data;
    end

    assign o_sum = r_sum;
endmodule

// File: rtl/program_loader.sv
// program_loader: streams a length-prefixed, checksummed image into instruction memory
// and releases the CPU from reset only after the image checks out.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MAX_WORDS   = 256,
    parameter int HOLD_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    program_loader_if.slave bus
);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 2);

    state_t            r_state;
    logic [CNT_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_idx;
    logic [HOLD_W-1:0] r_hold;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_cpu_reset;
    logic              r_done;
    logic              r_error;
    logic [DATA_W-1:0] w_sum;
    logic              w_xfer;
    logic              w_start_ok;

    assign bus.in_ready  = r_state inside {ST_LEN, ST_DATA, ST_CSUM};
    assign bus.busy      = r_state inside {ST_LEN, ST_DATA, ST_CSUM, ST_HOLD};
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.cpu_reset = r_cpu_reset;
    assign bus.done      = r_done;
    assign bus.error     = r_error;

    assign w_xfer     = bus.in_valid && bus.in_ready;
    assign w_start_ok = bus.start && (r_state inside {ST_IDLE, ST_DONE, ST_ERR});

    loader_csum_acc #(.W(DATA_W)) u_csum (
        .clock  (clock),
        .reset  (reset),
        .i_clr  (w_start_ok || r_state == ST_IDLE),
        .i_en   (w_xfer && r_state == ST_DATA),
        .i_data (bus.in_data),
        .o_sum  (w_sum)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_idx       <= '0;
            r_hold      <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_start_ok) begin
                r_state     <= ST_LEN;
                r_cpu_reset <= 1'b1;
                r_done      <= 1'b0;
                r_error     <= 1'b0;
            end else begin
                case (r_state)
                    ST_LEN: if (w_xfer) begin
                        if (bus.in_data == '0 || bus.in_data > DATA_W'(MAX_WORDS)) begin
                            r_state <= ST_ERR;
                            r_error <= 1'b1;
                        end else begin
                            r_len   <= bus.in_data[CNT_W-1:0];
                            r_idx   <= '0;
                            r_state <= ST_DATA;
                        end
                    end
                    ST_DATA: if (w_xfer) begin
                        r_we    <= 1'b1;
                        r_addr  <= r_idx[ADDR_W-1:0];
                        r_wdata <= bus.in_data;
                        r_idx   <= r_idx + CNT_W'(1);
                        if (r_idx + CNT_W'(1) == r_len) r_state <= ST_CSUM;
                    end
                    ST_CSUM: if (w_xfer) begin
                        r_state <= (bus.in_data == w_sum) ? ST_HOLD : ST_ERR;
                        r_error <= bus.in_data != w_sum;
                        r_hold  <= HOLD_W'(HOLD_CYCLES);
                    end
                    // Release happens on the edge the countdown expires, so done and
                    // cpu_reset change together.
                    ST_HOLD: begin
                        if (r_hold <= HOLD_W'(1)) begin
                            r_state     <= ST_DONE;
                            r_cpu_reset <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_hold <= r_hold - HOLD_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed loads checked every cycle against a word-counting
// transaction model, plus literal expectations for the plan's key outcomes.
module tb_program_loader;
    import loader_pkg::*;

    localparam int HOLD = 4;
    localparam int MAXW = 256;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    program_loader_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    program_loader #(.ADDR_W(8), .DATA_W(16), .MAX_WORDS(MAXW), .HOLD_CYCLES(HOLD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: counts accepted words of the current load and derives every output from that.
    bit          m_init   = 0;
    bit          m_active = 0;
    bit          m_done   = 0;
    bit          m_err    = 0;
    bit          m_we     = 0;
    int          m_n      = 0;
    int          m_len    = 0;
    int          m_ok     = -1;
    logic [15:0] m_sum    = '0;
    logic [7:0]  m_addr   = '0;
    logic [15:0] m_wdata  = '0;

    always @(posedge clock) begin
        m_init = 1;
        m_we   = 0;
        if (reset) begin
            m_active = 0;
            m_done   = 0;
            m_err    = 0;
        end else if (bus.start && !m_active) begin
            m_active = 1;
            m_n      = 0;
            m_sum    = '0;
            m_done   = 0;
            m_err    = 0;
            m_ok     = -1;
        end else if (m_active && m_ok >= 0) begin
            m_ok++;
            if (m_ok == HOLD) begin
                m_active = 0;
                m_done   = 1;
            end
        end else if (m_active && bus.in_valid) begin
            if (m_n == 0) begin
                if (bus.in_data == 16'd0 || int'(bus.in_data) > MAXW) begin
                    m_err    = 1;
                    m_active = 0;
                end else m_len = int'(bus.in_data);
            end else if (m_n <= m_len) begin
                m_we    = 1;
                m_addr  = 8'(m_n - 1);
                m_wdata = bus.in_data;
                m_sum   = m_sum + bus.in_data;
            end else if (bus.in_data == m_sum) m_ok = 0;
            else begin
                m_err    = 1;
                m_active = 0;
            end
            m_n++;
        end
    end

    logic [15:0] img [256];
    int          wcount = 0;

    always @(negedge clock) begin
        if (m_init) begin
            chk("in_ready", 32'(bus.in_ready), 32'(m_active && m_ok < 0));
            chk("busy", 32'(bus.busy), 32'(m_active));
            chk("cpu_reset", 32'(bus.cpu_reset), 32'(!m_done));
            chk("done", 32'(bus.done), 32'(m_done));
            chk("error", 32'(bus.error), 32'(m_err));
            chk("mem_we", 32'(bus.mem_we), 32'(m_we));
            if (m_we) begin
                chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
                chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
            end
            if (bus.mem_we === 1'b1) begin
                img[bus.mem_addr] = bus.mem_wdata;
                wcount++;
            end
        end
    end

    logic [15:0] q [$];

    task automatic settle(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input int gap);
        int t;
        repeat (gap) @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t == 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: word %0h never accepted", d);
        end
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic play(input int maxgap, input bit midstart);
        foreach (q[i]) begin
            send(q[i], maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
            if (midstart && i == 2) start_pulse();
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!bus.done && t < 40) begin
            @(negedge clock);
            t++;
        end
        chk("done_reached", 32'(bus.done), 32'd1);
    endtask

    int base;
    int n;

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        settle(3);
        chk("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_error", 32'(bus.error), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Good load
        base = wcount;
        start_pulse();
        q = '{16'h0003, 16'h1111, 16'h2222, 16'hF000, 16'h2333};
        play(0, 0);
        n = 0;
        while (bus.cpu_reset && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("hold_cycles", 32'(n), 32'd4);
        #1;
        chk("good_writes", 32'(wcount - base), 32'd3);
        chk("good_img0", 32'(img[0]), 32'h1111);
        chk("good_img1", 32'(img[1]), 32'h2222);
        chk("good_img2", 32'(img[2]), 32'hF000);
        chk("good_model_sum", 32'(m_sum), 32'h2333);
        chk("good_done", 32'(bus.done), 32'd1);
        chk("good_error", 32'(bus.error), 32'd0);

        // Bad checksum
        base = wcount;
        start_pulse();
        q = '{16'h0003, 16'h1111, 16'h2222, 16'hF000, 16'h2334};
        play(0, 0);
        settle(6);
        chk("badcs_writes", 32'(wcount - base), 32'd3);
        chk("badcs_error", 32'(bus.error), 32'd1);
        chk("badcs_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("badcs_done", 32'(bus.done), 32'd0);

        // Bad lengths
        foreach (q[i]) q[i] = 16'h0;
        q = '{16'h0000};
        for (int k = 0; k < 2; k++) begin
            base = wcount;
            @(negedge clock);
            start_pulse();
            play(0, 0);
            settle(3);
            chk("badlen_writes", 32'(wcount - base), 32'd0);
            chk("badlen_error", 32'(bus.error), 32'd1);
            chk("badlen_in_ready", 32'(bus.in_ready), 32'd0);
            q = '{16'h0101};
        end

        // Gaps and an ignored mid-DATA start
        img[0] = '0;
        img[1] = '0;
        img[2] = '0;
        @(negedge clock);
        start_pulse();
        q = '{16'h0003, 16'h1111, 16'h2222, 16'hF000, 16'h2333};
        play(5, 1);
        wait_done();
        #1;
        chk("gap_img0", 32'(img[0]), 32'h1111);
        chk("gap_img1", 32'(img[1]), 32'h2222);
        chk("gap_img2", 32'(img[2]), 32'hF000);

        // Reset after the 2nd data word
        start_pulse();
        send(16'h0003, 0);
        send(16'h1111, 0);
        send(16'h2222, 0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid_rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
        base = wcount;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0005;
        settle(5);
        bus.in_valid = 1'b0;
        chk("mid_rst_no_writes", 32'(wcount - base), 32'd0);
        start_pulse();
        play(0, 0);
        wait_done();

        // Reload after DONE
        settle(2);
        base = wcount;
        start_pulse();
        #1;
        chk("reload_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("reload_done", 32'(bus.done), 32'd0);
        q = '{16'h0001, 16'hABCD, 16'hABCD};
        play(0, 0);
        wait_done();
        #1;
        chk("reload_writes", 32'(wcount - base), 32'd1);
        chk("reload_img0", 32'(img[0]), 32'hABCD);

        settle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
